// File: rtl/boot_sequencer_if.sv
// Host byte-stream link feeding the boot sequencer's instruction store.
interface boot_sequencer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/boot_sequencer.sv
// Instruction store plus run control: load image from host, run core,
// detect jump-to-self halt and enforce a run-cycle watchdog.
module boot_sequencer #(
    parameter int PC_W       = 16,
    parameter int AW         = 8,
    parameter int CNT_W      = 24,
    parameter int MAX_CYCLES = 1000000
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic [AW:0]        len_i,
    boot_sequencer_if.slave    rx,
    output logic               cpu_rst_o,
    input  logic [PC_W-1:0]    cpu_pc_i,
    output logic [15:0]        cpu_instr_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   cycles_o
);
    localparam int DEPTH = 2 ** AW;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_RUN  = 3'd2;
    localparam logic [2:0] S_HALT = 3'd3;
    localparam logic [2:0] S_TOUT = 3'd4;

    localparam logic [CNT_W-1:0] MAXC  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] LASTC = CNT_W'(MAX_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [AW-1:0]    last_q, last_d;
    logic             phase_q, phase_d;
    logic [7:0]       lo_q, lo_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [PC_W-1:0]  prev_pc_q, prev_pc_d;
    logic             prev_valid_q, prev_valid_d;

    logic [15:0] mem [DEPTH];

    logic xfer;
    logic wr_en;
    logic halt_hit;
    logic pc_in_range;

    assign xfer        = rx.rx_valid && (state_q == S_LOAD);
    assign wr_en       = xfer && phase_q && !abort_i;
    assign halt_hit    = prev_valid_q && (cpu_pc_i == prev_pc_q);
    assign pc_in_range = (cpu_pc_i >> AW) == '0;

    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        last_d       = last_q;
        phase_d      = phase_q;
        lo_d         = lo_q;
        cycles_d     = cycles_q;
        prev_pc_d    = prev_pc_q;
        prev_valid_d = prev_valid_q;
        case (state_q)
            S_IDLE, S_HALT, S_TOUT: begin
                if (start_i) begin
                    cycles_d     = '0;
                    prev_valid_d = 1'b0;
                    wr_addr_d    = '0;
                    phase_d      = 1'b0;
                    // len above the depth clamps to the last address
                    last_d  = len_i[AW] ? '1 : len_i[AW-1:0] - AW'(1);
                    state_d = (len_i == '0) ? S_RUN : S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else if (xfer) begin
                    phase_d = !phase_q;
                    if (!phase_q) begin
                        lo_d = rx.rx_data;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                        if (wr_addr_q == last_q) begin
                            state_d      = S_RUN;
                            prev_valid_d = 1'b0;
                        end
                    end
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (cycles_q != MAXC) begin
                        cycles_d = cycles_q + CNT_W'(1);
                    end
                    prev_pc_d    = cpu_pc_i;
                    prev_valid_d = 1'b1;
                    if (halt_hit) begin
                        state_d = S_HALT;
                    end else if (cycles_q == LASTC) begin
                        state_d = S_TOUT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            wr_addr_q    <= '0;
            last_q       <= '0;
            phase_q      <= 1'b0;
            lo_q         <= '0;
            cycles_q     <= '0;
            prev_pc_q    <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            last_q       <= last_d;
            phase_q      <= phase_d;
            lo_q         <= lo_d;
            cycles_q     <= cycles_d;
            prev_pc_q    <= prev_pc_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr_q] <= {rx.rx_data, lo_q};
        end
    end

    assign rx.rx_ready = (state_q == S_LOAD);
    assign cpu_rst_o   = (state_q == S_RUN);
    assign busy_o      = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done_o      = (state_q == S_HALT);
    assign timeout_o   = (state_q == S_TOUT);
    assign cycles_o    = cycles_q;
    assign cpu_instr_o = (cpu_rst_o && pc_in_range) ?
                         mem[cpu_pc_i[AW-1:0]] : 16'h0000;
endmodule

// File: tb/tb_boot_sequencer.sv
// Randomized bench for boot_sequencer against a transaction-level
// model of load/run/halt/watchdog behaviour.
module tb_boot_sequencer;
    localparam int AW    = 8;
    localparam int DEPTH = 2 ** AW;
    localparam int MAXC  = 10;

    localparam int M_IDLE = 0;
    localparam int M_LOAD = 1;
    localparam int M_RUN  = 2;
    localparam int M_HALT = 3;
    localparam int M_TOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [8:0]  len = '0;
    logic [15:0] cpu_pc = '0;
    logic        cpu_rst;
    logic [15:0] cpu_instr;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [23:0] cycles;

    boot_sequencer_if host ();

    boot_sequencer #(
        .PC_W(16), .AW(AW), .CNT_W(24), .MAX_CYCLES(MAXC)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .start_i(start), .abort_i(abort), .len_i(len),
        .rx(host),
        .cpu_rst_o(cpu_rst), .cpu_pc_i(cpu_pc),
        .cpu_instr_o(cpu_instr),
        .busy_o(busy), .done_o(done), .timeout_o(timeout),
        .cycles_o(cycles)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase of the sequencer, image contents,
    // words still owed by the host, and run-cycle bookkeeping.
    int          m_state  = M_IDLE;
    int          m_target = 0;
    int          m_words  = 0;
    int          m_cycles = 0;
    bit          m_have_lo = 0;
    logic [7:0]  m_lo = '0;
    bit          m_first = 1;
    logic [15:0] m_lastpc = '0;
    logic [15:0] m_mem [DEPTH];
    bit          m_known [DEPTH];

    task automatic model_step();
        bit halted;
        case (m_state)
            M_IDLE, M_HALT, M_TOUT: begin
                if (start) begin
                    m_cycles = 0;
                    m_first  = 1;
                    if (len == 0) begin
                        m_state = M_RUN;
                    end else begin
                        m_state   = M_LOAD;
                        m_target  = (int'(len) > DEPTH) ? DEPTH : int'(len);
                        m_words   = 0;
                        m_have_lo = 0;
                    end
                end
            end
            M_LOAD: begin
                if (abort) begin
                    m_state = M_IDLE;
                end else if (host.rx_valid) begin
                    if (!m_have_lo) begin
                        m_lo      = host.rx_data;
                        m_have_lo = 1;
                    end else begin
                        m_mem[m_words]   = {host.rx_data, m_lo};
                        m_known[m_words] = 1;
                        m_words++;
                        m_have_lo = 0;
                        if (m_words == m_target) begin
                            m_state = M_RUN;
                            m_first = 1;
                        end
                    end
                end
            end
            M_RUN: begin
                if (abort) begin
                    m_state = M_IDLE;
                end else begin
                    halted = !m_first && (cpu_pc == m_lastpc);
                    if (halted) m_state = M_HALT;
                    else if (m_cycles + 1 == MAXC) m_state = M_TOUT;
                    m_cycles = (m_cycles + 1 > MAXC) ? MAXC : m_cycles + 1;
                    m_lastpc = cpu_pc;
                    m_first  = 0;
                end
            end
            default: m_state = M_IDLE;
        endcase
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_state  = M_IDLE;
                m_cycles = 0;
            end else begin
                model_step();
            end
        end
    end

    initial forever begin
        @(negedge clk);
        #2;
        chk("rx_ready", host.rx_ready, m_state == M_LOAD);
        chk("cpu_rst", cpu_rst, m_state == M_RUN);
        chk("busy", busy, m_state == M_LOAD || m_state == M_RUN);
        chk("done", done, m_state == M_HALT);
        chk("timeout", timeout, m_state == M_TOUT);
        chk("cycles", cycles, m_cycles);
        if (m_state == M_RUN && cpu_pc < DEPTH) begin
            if (m_known[cpu_pc[AW-1:0]])
                chk("instr", cpu_instr, m_mem[cpu_pc[AW-1:0]]);
        end else begin
            chk("instr_zero", cpu_instr, 16'h0000);
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "bench time limit");
    end

    task automatic start_cmd(input int l);
        @(negedge clk);
        start = 1'b1;
        len   = 9'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap,
                             input bit noise);
        repeat (gap) begin
            @(negedge clk);
            host.rx_valid = 1'b0;
            host.rx_data  = 8'($urandom);
            start = 1'b0;
        end
        @(negedge clk);
        host.rx_valid = 1'b1;
        host.rx_data  = b;
        start = noise && ($urandom_range(0, 7) == 0);
        len   = 9'($urandom_range(0, 20));
    endtask

    task automatic end_bytes();
        @(negedge clk);
        host.rx_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_random();
        for (int c = 0; c < 14; c++) begin
            if (m_state != M_RUN) break;
            if (c == 3 && $urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #3;
                rst_n = 1'b0;
                #1;
                chk("async_rst", {cpu_rst, busy}, 2'b00);
                @(negedge clk);
                rst_n = 1'b1;
                break;
            end
            if ($urandom_range(0, 2) != 0)
                cpu_pc = ($urandom_range(0, 9) == 0) ? 16'($urandom) :
                         16'($urandom_range(0, DEPTH - 1));
            start = ($urandom_range(0, 7) == 0);
            len   = 9'($urandom_range(0, 20));
            abort = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
        if (m_state == M_RUN) begin
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    logic [15:0] img [DEPTH];

    initial begin
        host.rx_valid = 1'b0;
        host.rx_data  = '0;

        // reset values
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_cpu_rst", cpu_rst, 1'b0);
        chk("rst_rx_ready", host.rx_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        chk("rst_cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // three-word load with gaps, then walk pc 0,1,2,2 to halt
        start_cmd(3);
        #2;
        chk("load_rx_ready", host.rx_ready, 1'b1);
        send_byte(8'h01, 1, 0);
        send_byte(8'hA0, 0, 0);
        send_byte(8'h02, 2, 0);
        send_byte(8'hB0, 0, 0);
        send_byte(8'h03, 1, 0);
        send_byte(8'hC0, 0, 0);
        end_bytes();
        cpu_pc = 16'd0;
        #2;
        chk("run_cpu_rst", cpu_rst, 1'b1);
        chk("word0", cpu_instr, 16'hA001);
        @(negedge clk);
        cpu_pc = 16'd1;
        #2;
        chk("word1", cpu_instr, 16'hB002);
        @(negedge clk);
        cpu_pc = 16'd2;
        #2;
        chk("word2", cpu_instr, 16'hC003);
        @(negedge clk);
        cpu_pc = 16'd2;
        @(negedge clk);
        #2;
        chk("halt_done", done, 1'b1);
        chk("halt_cycles", cycles, 4);
        chk("halt_cpu_rst", cpu_rst, 1'b0);

        // rerun with a free-running pc until the watchdog fires
        start_cmd(0);
        cpu_pc = 16'd0;
        #2;
        chk("rerun_rx_ready", host.rx_ready, 1'b0);
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            cpu_pc = 16'(i);
        end
        @(negedge clk);
        #2;
        chk("wd_timeout", timeout, 1'b1);
        chk("wd_cycles", cycles, 10);
        chk("wd_done", done, 1'b0);

        // abort after three bytes: word 0 replaced, word 1 kept
        start_cmd(2);
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        send_byte(8'h33, 0, 0);
        @(negedge clk);
        host.rx_valid = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        chk("abort_busy", busy, 1'b0);
        start_cmd(0);
        cpu_pc = 16'd0;
        #2;
        chk("abort_word0", cpu_instr, 16'h2211);
        @(negedge clk);
        cpu_pc = 16'd1;
        #2;
        chk("abort_word1", cpu_instr, 16'hB002);
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #2;
        chk("sa_busy", busy, 1'b0);
        chk("sa_cpu_rst", cpu_rst, 1'b0);

        // async reset mid-run
        start_cmd(0);
        cpu_pc = 16'd5;
        @(negedge clk);
        cpu_pc = 16'd6;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_cpu_rst", cpu_rst, 1'b0);
        chk("async_cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // oversized len clamps to a full image
        for (int i = 0; i < DEPTH; i++) img[i] = 16'($urandom);
        start_cmd(DEPTH + 5);
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(img[i][7:0], 0, 0);
            send_byte(img[i][15:8], 0, 0);
        end
        end_bytes();
        cpu_pc = 16'(DEPTH - 1);
        #2;
        chk("big_cpu_rst", cpu_rst, 1'b1);
        chk("big_last", cpu_instr, img[DEPTH-1]);
        @(negedge clk);
        cpu_pc = 16'(DEPTH);
        #2;
        chk("pc_oob", cpu_instr, 16'h0000);
        @(negedge clk);
        cpu_pc = 16'hFFFF;
        #2;
        chk("pc_max", cpu_instr, 16'h0000);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;

        // randomized loads, reruns, aborts and runs
        for (int it = 0; it < 80; it++) begin
            int n;
            int ab;
            if ($urandom_range(0, 3) == 0) begin
                start_cmd(0);
            end else begin
                n  = $urandom_range(1, 12);
                ab = ($urandom_range(0, 3) == 0) ?
                     $urandom_range(0, 2 * n - 1) : -1;
                start_cmd(n);
                for (int b = 0; b < 2 * n; b++) begin
                    if (b == ab) begin
                        @(negedge clk);
                        host.rx_valid = 1'b0;
                        start = 1'b0;
                        abort = 1'b1;
                        @(negedge clk);
                        abort = 1'b0;
                        break;
                    end
                    send_byte(8'($urandom), $urandom_range(0, 2), 1);
                end
                if (ab < 0) end_bytes();
            end
            run_random();
        end

        @(negedge clk);
        #3;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
